// File: rtl/cpu_defs.sv
// Shared fetch-stage definitions: FSM encoding, instruction width and PC step.
package cpu_defs;

  localparam int unsigned InstWidth = 32;
  localparam logic [31:0] PcIncr    = 32'd4;
  // Clears the two low address bits so the PC stays word-aligned
  localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StStall    = 2'd1,
    StRedirect = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads on en, inserts a bubble on flush, holds otherwise.
module if_id_reg
  import cpu_defs::*;
#(
  parameter logic [InstWidth-1:0] NOP_INST = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 flush,
  input  logic [31:0]          pc_in,
  input  logic [InstWidth-1:0] inst_in,
  output logic [31:0]          pc_out,
  output logic [InstWidth-1:0] inst_out,
  output logic                 valid_out
);

  logic [31:0]          pc_q, pc_d;
  logic [InstWidth-1:0] inst_q, inst_d;
  logic                 valid_q, valid_d;

  // Next-state select: flush wins over load, otherwise hold
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = 32'd0;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (en) begin
      pc_d    = pc_in;
      inst_d  = inst_in;
      valid_d = 1'b1;
    end
  end

  // Register update with synchronous reset to an empty slot
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= 32'd0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out    = pc_q;
  assign inst_out  = inst_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, stall/redirect FSM and fetch counter.
module inst_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0]          RESET_PC = 32'd0,
  parameter logic [InstWidth-1:0] NOP_INST = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_addr,
  output logic [31:0]          address,
  input  logic [InstWidth-1:0] Inst,
  output logic [31:0]          pc_out,
  output logic [InstWidth-1:0] inst_out,
  output logic                 valid_out,
  output logic [31:0]          fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  pc_next;
  logic         load_en;
  logic         flush;

  // Wraps modulo 2^32 naturally
  assign pc_next = pc_q + PcIncr;

  // Next-state logic: redirect beats freeze; STALL and REDIRECT both resolve like RUN
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    load_en = 1'b0;
    flush   = 1'b0;
    if (branch_taken) begin
      state_d = StRedirect;
      pc_d    = branch_addr & AlignMask;
      flush   = 1'b1;
    end else begin
      unique case (state_q)
        StStall: begin
          if (freeze) begin
            state_d = StStall;
          end else begin
            state_d = StRun;
            pc_d    = pc_next;
            count_d = count_q + 32'd1;
            load_en = 1'b1;
          end
        end
        StRun, StRedirect: begin
          if (freeze) begin
            state_d = StStall;
          end else begin
            state_d = StRun;
            pc_d    = pc_next;
            count_d = count_q + 32'd1;
            load_en = 1'b1;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // State, PC and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC & AlignMask;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign address     = pc_q;
  assign fetch_count = count_q;

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .en       (load_en),
    .flush    (flush),
    .pc_in    (pc_next),
    .inst_in  (Inst),
    .pc_out   (pc_out),
    .inst_out (inst_out),
    .valid_out(valid_out)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch; memory word at byte address a reads as 0x1000_0000 + a.
module tb_inst_fetch;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken;
  logic [31:0] branch_addr, address, inst, pc_out, inst_out, fetch_count;
  logic        valid_out;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign inst = 32'h1000_0000 + address;

  inst_fetch #(
    .RESET_PC(32'd0),
    .NOP_INST(Nop)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .address     (address),
    .Inst        (inst),
    .pc_out      (pc_out),
    .inst_out    (inst_out),
    .valid_out   (valid_out),
    .fetch_count (fetch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] io,
                         input logic [31:0] po, input logic v, input logic [31:0] cnt);
    chk({tag, ".address"}, address, addr);
    chk({tag, ".inst_out"}, inst_out, io);
    chk({tag, ".pc_out"}, pc_out, po);
    chk({tag, ".valid_out"}, {31'd0, valid_out}, {31'd0, v});
    chk({tag, ".fetch_count"}, fetch_count, cnt);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
    tick();
    // Reset must override a concurrent branch and freeze
    branch_taken = 1'b1; branch_addr = 32'h40; freeze = 1'b1;
    tick();
    chk_all("reset", 32'd0, Nop, 32'd0, 1'b0, 32'd0);

    // Free run of 7 fetches from 0
    rst = 1'b0; branch_taken = 1'b0; freeze = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk_all($sformatf("run%0d", i), 32'd4 * i, 32'h1000_0000 + 32'd4 * (i - 1),
              32'd4 * i, 1'b1, i);
    end

    // Redirect to 8, then freeze 3 cycles
    branch_taken = 1'b1; branch_addr = 32'd8;
    tick();
    chk_all("br8", 32'd8, Nop, 32'd0, 1'b0, 32'd7);
    branch_taken = 1'b0; freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("frz%0d", i), 32'd8, Nop, 32'd0, 1'b0, 32'd7);
    end
    freeze = 1'b0;
    tick();
    chk_all("unfrz", 32'd12, 32'h1000_0008, 32'd12, 1'b1, 32'd8);

    // Branch with freeze in the same cycle, misaligned target
    branch_taken = 1'b1; branch_addr = 32'h17; freeze = 1'b1;
    tick();
    chk_all("brfrz", 32'h14, Nop, 32'd0, 1'b0, 32'd8);
    branch_taken = 1'b0; freeze = 1'b0;
    tick();
    chk_all("brfrz+1", 32'h18, 32'h1000_0014, 32'd24, 1'b1, 32'd9);

    // Back-to-back branches to 0, 8, 16
    for (int i = 0; i < 3; i++) begin
      branch_taken = 1'b1; branch_addr = 32'd8 * i;
      tick();
      chk_all($sformatf("b2b%0d", i), 32'd8 * i, Nop, 32'd0, 1'b0, 32'd9);
    end
    branch_taken = 1'b0;
    tick();
    chk_all("b2b_end", 32'h14, 32'h1000_0010, 32'h14, 1'b1, 32'd10);

    // PC wrap at the top of the address space
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFF;
    tick();
    chk_all("wrap_br", 32'hFFFF_FFFC, Nop, 32'd0, 1'b0, 32'd10);
    branch_taken = 1'b0;
    tick();
    chk_all("wrap", 32'd0, 32'h0FFF_FFFC, 32'd0, 1'b1, 32'd11);
    tick();
    chk_all("wrap+1", 32'd4, 32'h1000_0000, 32'd4, 1'b1, 32'd12);

    // Reset during a stall discards everything
    freeze = 1'b1;
    tick();
    chk_all("stall", 32'd4, 32'h1000_0000, 32'd4, 1'b1, 32'd12);
    rst = 1'b1;
    tick();
    chk_all("rst_stall", 32'd0, Nop, 32'd0, 1'b0, 32'd0);
    rst = 1'b0; freeze = 1'b0;
    tick();
    chk_all("post_rst", 32'd4, 32'h1000_0000, 32'd4, 1'b1, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The module SHALL take parameter RESET_PC, default 32'd0, as the PC loaded on reset.
REQ-002 The module SHALL take parameter NOP_INST, default 32'b0, as the instruction placed in the IF/ID register when it holds no valid instruction.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
REQ-005 The module SHALL have port freeze, input, 1 bit, hazard stall; hold the PC and the IF/ID register.
REQ-006 The module SHALL have port branch_taken, input, 1 bit, redirect request from a later stage.
REQ-007 The module SHALL have port branch_addr, input, 32 bits, redirect target byte address.
REQ-008 The module SHALL have port address, output, 32 bits, byte address presented to the combinational instruction memory.
REQ-009 The module SHALL have port Inst, input, 32 bits, instruction returned combinationally for address.
REQ-010 The module SHALL have port pc_out, output, 32 bits, registered PC+4 of the instruction held in IF/ID.
REQ-011 The module SHALL have port inst_out, output, 32 bits, registered instruction held in IF/ID.
REQ-012 The module SHALL have port valid_out, output, 1 bit, inst_out is a real fetched instruction.
REQ-013 The module SHALL have port fetch_count, output, 32 bits, number of instructions accepted into IF/ID since reset.

Function
REQ-014 address SHALL equal the PC register combinationally; the PC SHALL always be word-aligned, with bits [1:0] equal to 0.
REQ-015 The FSM SHALL have three states: RUN, STALL and REDIRECT; it SHALL enter RUN on reset.
REQ-016 In RUN with freeze=0 and branch_taken=0, each cycle SHALL apply all of: PC<=PC+4; inst_out<=Inst; pc_out<=PC+4; valid_out<=1; fetch_count increments.
REQ-017 In RUN, freeze=1 with branch_taken=0 SHALL hold the PC and the IF/ID register, leave fetch_count unchanged and move to STALL.
REQ-018 In STALL, remaining frozen SHALL hold everything; when freeze falls with branch_taken=0, the module SHALL perform a normal RUN fetch in that cycle and return to RUN.
REQ-019 branch_taken=1 in any state SHALL have priority over freeze, and SHALL apply all of: PC<={branch_addr[31:2],2'b00}; inst_out<=NOP_INST; valid_out<=0; pc_out<=0; fetch_count unchanged; next state REDIRECT.
REQ-020 REDIRECT SHALL last exactly one cycle and then behave as RUN, including its freeze and branch_taken handling in that cycle.
REQ-021 After branch_taken is sampled, the first valid instruction SHALL be the word at the target and SHALL appear on inst_out exactly 2 cycles later.
REQ-022 Back-to-back branch_taken SHALL retarget every cycle and keep valid_out=0 throughout.
REQ-023 PC arithmetic SHALL be modulo 2^32: 32'hFFFFFFFC+4 wraps to 0 with no error.
REQ-024 fetch_count SHALL wrap from 32'hFFFFFFFF to 0.

Reset
REQ-025 While rst=1 on a clock edge, the module SHALL apply all of: PC<=RESET_PC; inst_out<=NOP_INST; pc_out<=0; valid_out<=0; fetch_count<=0; state<=RUN.
REQ-026 rst SHALL override freeze and branch_taken.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL discard all pending state.
REQ-028 The first valid instruction after reset release SHALL be the one at RESET_PC, on inst_out one cycle after the first non-reset edge.

Structure
REQ-029 The FSM state encoding (RUN, STALL, REDIRECT), the instruction width constant (32) and the PC increment (4) SHALL reside in a shared package, cpu_defs.
REQ-030 The IF/ID register SHALL be a separate sub-module, if_id_reg, with ports clk, rst, en, flush, pc_in, inst_in, pc_out, inst_out and valid_out.
REQ-031 inst_fetch SHALL contain only the PC register, the FSM and the counter.

Verification
REQ-032 Scenario, reset then free run: rst 2 cycles, then run 7 cycles with memory at 0..24 -> address 0,4,...,24; inst_out follows one cycle behind; pc_out 4..28; valid_out=1; fetch_count=7.
REQ-033 Scenario, freeze: freeze=1 for 3 cycles at PC=8 -> address stays 8, inst_out/pc_out/fetch_count hold; the cycle freeze falls fetches from 8.
REQ-034 Scenario, branch with freeze: branch_taken=1, branch_addr=32'h17, freeze=1 in the same cycle -> PC=32'h14; next cycle valid_out=0 and inst_out=NOP_INST; following cycle inst_out=mem[20] and pc_out=24.
REQ-035 Scenario, back-to-back branches: branch_taken 3 consecutive cycles to 0, 8, 16 -> valid_out=0 for 3 cycles; then inst_out=mem[16]; fetch_count unchanged.
REQ-036 Scenario, wrap: force PC to 32'hFFFFFFFC via branch -> next address 0.
REQ-037 Scenario, reset mid-operation: rst asserted during STALL -> all outputs at reset values next cycle.
